// File: rtl/contador_param.sv
// Parametrised up/down counter: sync clear, clamped load, modulus, wrap or saturate.
// Optional registered compare output enabled by defining CONTADOR_MATCH_EN.
module contador_param #(
  parameter int unsigned      WIDTH    = 8,
  parameter longint unsigned  MOD      = 64'd1 << WIDTH,
  parameter bit               SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
`ifdef CONTADOR_MATCH_EN
  ,
  input  logic [WIDTH-1:0] match_val,
  output logic             match
`endif
);

  if (MOD < 64'd2 || MOD > (64'd1 << WIDTH)) begin : g_mod_check
    $error("contador_param: MOD must lie in 2..2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MOD - 64'd1);

  logic [WIDTH-1:0] q_q, q_d;
  logic             ovf_q, ovf_d;
  logic             at_top, at_bot;

  assign at_top = (q_q == MAXV);
  assign at_bot = (q_q == '0);

  always_comb begin
    q_d   = q_q;
    ovf_d = ovf_q;
    if (clear) begin
      q_d   = '0;
      ovf_d = 1'b0;
    end else if (load) begin
      q_d = (load_val > MAXV) ? MAXV : load_val;
    end else if (en) begin
      if (up) begin
        if (at_top) begin
          ovf_d = 1'b1;
          q_d   = SATURATE ? MAXV : '0;
        end else begin
          q_d = q_q + WIDTH'(1);
        end
      end else begin
        if (at_bot) begin
          ovf_d = 1'b1;
          q_d   = SATURATE ? '0 : MAXV;
        end else begin
          q_d = q_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ovf_q <= ovf_d;
    end
  end

  assign q   = q_q;
  assign ovf = ovf_q;
  assign tc  = en & (up ? at_top : at_bot);

`ifdef CONTADOR_MATCH_EN
  // Compare against the next count so the flag lines up with q, not one cycle behind.
  logic match_q, match_d;

  assign match_d = (q_d == match_val);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      match_q <= 1'b0;
    end else begin
      match_q <= match_d;
    end
  end

  assign match = match_q;
`endif

endmodule

// File: tb/tb_contador_param.sv
// Bench for contador_param: WIDTH=4, MOD=10, one wrapping and one saturating instance.
module tb_contador_param;

  localparam int M = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0, up = 1'b0, clear = 1'b0, load = 1'b0;
  logic [3:0] load_val = '0;
  logic [3:0] match_val = '0;
  logic [3:0] q0, q1;
  logic       tc0, tc1, ovf0, ovf1;
`ifdef CONTADOR_MATCH_EN
  logic       match0, match1;
`endif

  int passed = 0;
  int total  = 0;

  int  m_q[2];
  bit  m_ovf[2];
  bit  m_match[2];
  int  nx, raw;
  bit  nov;

  int dn0[4] = '{1, 0, 9, 8};
  int dn1[4] = '{1, 0, 0, 0};
  int su0[3] = '{9, 0, 1};

  always #5 clk = ~clk;

  contador_param #(.WIDTH(4), .MOD(64'd10), .SATURATE(1'b0)) dut0 (
    .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear), .load(load),
    .load_val(load_val), .q(q0), .tc(tc0), .ovf(ovf0)
`ifdef CONTADOR_MATCH_EN
    , .match_val(match_val), .match(match0)
`endif
  );

  contador_param #(.WIDTH(4), .MOD(64'd10), .SATURATE(1'b1)) dut1 (
    .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear), .load(load),
    .load_val(load_val), .q(q1), .tc(tc1), .ovf(ovf1)
`ifdef CONTADOR_MATCH_EN
    , .match_val(match_val), .match(match1)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference: integer arithmetic on the count range, out-of-range results are bound events.
  always @(posedge clk or negedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        m_q[k] <= 0; m_ovf[k] <= 1'b0; m_match[k] <= 1'b0;
      end else begin
        nx = m_q[k]; nov = m_ovf[k];
        if (clear) begin
          nx = 0; nov = 1'b0;
        end else if (load) begin
          nx = (int'(load_val) >= M) ? M - 1 : int'(load_val);
        end else if (en) begin
          raw = up ? m_q[k] + 1 : m_q[k] - 1;
          if (raw < 0 || raw >= M) begin
            nov = 1'b1;
            nx  = (k == 1) ? m_q[k] : (raw + M) % M;
          end else begin
            nx = raw;
          end
        end
        m_q[k]     <= nx;
        m_ovf[k]   <= nov;
        m_match[k] <= (nx == int'(match_val));
      end
    end
  end

  function automatic int model_tc(input int mq);
    if (!en) return 0;
    return up ? int'(mq == M - 1) : int'(mq == 0);
  endfunction

  always @(negedge clk) begin
    chk("q0", int'(q0), m_q[0]);
    chk("ovf0", int'(ovf0), int'(m_ovf[0]));
    chk("tc0", int'(tc0), model_tc(m_q[0]));
    chk("q1", int'(q1), m_q[1]);
    chk("ovf1", int'(ovf1), int'(m_ovf[1]));
    chk("tc1", int'(tc1), model_tc(m_q[1]));
`ifdef CONTADOR_MATCH_EN
    chk("match0", int'(match0), int'(m_match[0]));
    chk("match1", int'(match1), int'(m_match[1]));
`endif
  end

  task automatic cyc(input bit e, input bit u, input bit c, input bit l, input logic [3:0] lv);
    en = e; up = u; clear = c; load = l; load_val = lv;
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q0", int'(q0), 0);
    chk("rst_ovf0", int'(ovf0), 0);
    chk("rst_q1", int'(q1), 0);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      en = 1'b1; up = 1'b1;
      #1;
      chk("up_q_lit", int'(q0), i % 10);
      chk("up_tc_lit", int'(tc0), int'(i == 9));
      chk("up_ovf_lit", int'(ovf0), int'(i >= 10));
      @(posedge clk); #1;
    end
    chk("up_end_q0", int'(q0), 2);
    chk("up_end_q1", int'(q1), 9);
    chk("up_end_ovf1", int'(ovf1), 1);

    cyc(0, 0, 1, 0, 4'd0);
    cyc(0, 0, 0, 1, 4'd2);
    chk("ld2_q0", int'(q0), 2);
    chk("ld2_ovf0", int'(ovf0), 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0, 0, 4'd0);
      chk("dn_q0", int'(q0), dn0[i]);
      chk("dn_q1", int'(q1), dn1[i]);
      chk("dn_ovf0", int'(ovf0), int'(i >= 2));
      chk("dn_ovf1", int'(ovf1), int'(i >= 2));
    end

    cyc(0, 0, 1, 0, 4'd0);
    cyc(0, 0, 0, 1, 4'd8);
    chk("ld8_q1", int'(q1), 8);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 0, 0, 4'd0);
      chk("sat_up_q1", int'(q1), 9);
      chk("sat_up_q0", int'(q0), su0[i]);
      chk("sat_up_ovf1", int'(ovf1), int'(i >= 1));
    end
    cyc(0, 0, 0, 1, 4'd1);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0, 4'd0);
      chk("sat_dn_q1", int'(q1), 0);
    end

    cyc(0, 0, 0, 1, 4'd15);
    chk("clamp_q0", int'(q0), 9);
    chk("clamp_q1", int'(q1), 9);
    cyc(1, 1, 1, 1, 4'd7);
    chk("clr_pri_q0", int'(q0), 0);
    chk("clr_pri_ovf0", int'(ovf0), 0);
    chk("clr_pri_ovf1", int'(ovf1), 0);
    cyc(1, 1, 0, 1, 4'd3);
    chk("ld_pri_q0", int'(q0), 3);
    chk("ld_pri_q1", int'(q1), 3);

    cyc(0, 0, 0, 1, 4'd9);
    cyc(1, 1, 0, 0, 4'd0);
    chk("wrap_q0", int'(q0), 0);
    chk("wrap_ovf0", int'(ovf0), 1);
    repeat (6) cyc(1, 1, 0, 0, 4'd0);
    chk("pre_rst_q0", int'(q0), 6);
    #2 reset = 1'b0;
    #1;
    chk("arst_q0", int'(q0), 0);
    chk("arst_ovf0", int'(ovf0), 0);
    chk("arst_q1", int'(q1), 0);
    @(posedge clk); #1;
    chk("arst_hold_q0", int'(q0), 0);
    reset = 1'b1;
    cyc(0, 0, 0, 0, 4'd0);

`ifdef CONTADOR_MATCH_EN
    match_val = 4'd5;
    cyc(0, 0, 1, 0, 4'd0);
    for (int i = 0; i < 8; i++) begin
      cyc(1, 1, 0, 0, 4'd0);
      chk("match_cnt", int'(match0), int'(i + 1 == 5));
    end
    cyc(0, 0, 0, 1, 4'd5);
    chk("match_load", int'(match0), 1);
`endif

    cyc(0, 0, 0, 0, 4'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/contador_param.md
# contador_param

Parametrised up/down counter with synchronous clear, parallel load, programmable modulus and selectable wrap or saturate behaviour. It is the general-purpose successor to the fixed 2-bit enable counter, for timers, dividers and address generators in the lab designs. Outputs are a registered count, a combinational terminal-count flag and a sticky overflow flag.

## Interface

- `WIDTH`, default 8: count register width in bits.
- `MOD`, default 2**WIDTH: modulus; the count range is 0..MOD-1. Legal values are 2..2**WIDTH.
- `SATURATE`, default 0: 0 selects wrap-around at the bounds, 1 selects hold at the bounds.

- `clk`, input, 1 bit: single clock; all state updates on the rising edge.
- `reset`, input, 1 bit: asynchronous, active-low reset.
- `en`, input, 1 bit: count enable.
- `up`, input, 1 bit: direction; 1 counts up, 0 counts down.
- `clear`, input, 1 bit: synchronous clear of `q` and `ovf`.
- `load`, input, 1 bit: synchronous parallel load.
- `load_val`, input, WIDTH bits: value for `load`.
- `q`, output, WIDTH bits: registered count.
- `tc`, output, 1 bit: terminal count, combinational.
- `ovf`, output, 1 bit: sticky overflow/underflow flag, registered.
- `match_val`, input, WIDTH bits: compare value. Present only with `CONTADOR_MATCH_EN`.
- `match`, output, 1 bit: registered compare flag. Present only with `CONTADOR_MATCH_EN`.

## Operation

- **Reset (`reset`=0, any time, asynchronous):**
  - `q`=0, `ovf`=0, `match`=0 immediately.
  - Counting resumes on the first rising edge after `reset` returns to 1.
- **Priority per edge:** `clear` > `load` > `en`. No action means `q` holds.
- **`clear`=1:**
  - `q`←0, `ovf`←0.
  - `load` and `en` are ignored that cycle.
- **`load`=1:**
  - `q`←`load_val`.
  - If `load_val` ≥ MOD, `q`←MOD-1 (clamped).
  - `ovf` is unchanged.
- **`en`=1, `up`=1:**
  - If `q`<MOD-1, `q`←`q`+1.
  - At `q`=MOD-1: with SATURATE=0, `q`←0; with SATURATE=1, `q` holds at MOD-1.
  - In both cases at the bound, `ovf`←1.
- **`en`=1, `up`=0:**
  - If `q`>0, `q`←`q`-1.
  - At `q`=0: with SATURATE=0, `q`←MOD-1; with SATURATE=1, `q` holds at 0.
  - In both cases at the bound, `ovf`←1.
- **`tc`** = `en` & (`up` ? `q`==MOD-1 : `q`==0). It is high exactly in the cycle whose rising edge performs the wrap or saturation attempt.
- **`ovf`** stays 1 until `clear` or `reset`. It sets even when SATURATE=1 blocks the count.
- **Arithmetic:** all comparisons are unsigned at WIDTH bits. No intermediate value ever exceeds MOD-1. If MOD=2**WIDTH, wrap is natural binary roll-over.
- **Illegal MOD:** MOD outside 2..2**WIDTH is a configuration error and must be flagged by an elaboration-time check.

## Timing

- `q` latency is 1 cycle: the input sampled at edge N is visible after edge N.
- `tc` is purely combinational from `q`, `en` and `up`, with no added latency.
- `ovf` is set at the same edge that performs the bound event, so it is visible in the following cycle.
- Changing `up` takes effect on the next enabled edge; there is no dead cycle.
- `clear` and `load` asserted together: `clear` wins, giving `q`=0 and `ovf`=0.
- `load` and `en` asserted together: the load wins and no count is applied that cycle.

## Configuration

- **`CONTADOR_MATCH_EN` defined:**
  - Adds the `match_val` input and the `match` output.
  - `match` is registered: `match`←(next value of `q` == `match_val`). It is therefore high in the same cycle that `q` equals `match_val`, including after a load or clear.
  - `match` resets to 0.
- **`CONTADOR_MATCH_EN` undefined:** both ports and the compare logic are absent. All other behaviour is identical.

## Test plan

- **Reset and basic up-count (WIDTH=4, MOD=10, SATURATE=0):**
  - Stimulus: `reset`=0 → 1, then `en`=1, `up`=1 for 12 cycles.
  - Required: `q` runs 0,1,…,9,0,1,2.
  - Required: `tc`=1 only while `q`=9.
  - Required: `ovf`=1 from the cycle after the 9→0 edge onward.
- **Down-count and underflow wrap:**
  - Stimulus: load 2, then count down 4 cycles.
  - Required: `q` runs 2,1,0,9,8.
  - Required: `ovf` sets after the 0→9 edge.
- **Saturate mode (SATURATE=1, MOD=10):**
  - Stimulus: load 8, then count up 3 cycles.
  - Required: `q` runs 8,9,9,9 and `ovf`=1.
  - Stimulus: then count down from 1 for 3 cycles.
  - Required: `q` runs 1,0,0,0.
- **Priority and clamping:**
  - `load_val`=15 with `load`=1 → `q`=9.
  - `clear`=1 with `load`=1 and `en`=1 in the same cycle → `q`=0, `ovf`=0.
  - `en`=1 with `load`=1 and `load_val`=3 → `q`=3.
- **Asynchronous reset mid-count:**
  - Stimulus: drop `reset` between edges while `q`=6.
  - Required: `q`=0 and `ovf`=0 before the next edge; `q` stays at 0 while `reset`=0.
- **Match (with `CONTADOR_MATCH_EN`):**
  - Stimulus: `match_val`=5, counting up from 0.
  - Required: `match`=1 exactly in the cycle `q`=5.
  - Stimulus: load 5.
  - Required: `match`=1 in the following cycle.
